// File: rtl/matrix_engine.sv
// matrix_engine: parametrised N x N matrix engine with internal operand banks
// A and B and result bank C. One operation runs per accepted start:
//   mode 0/3 : C = A * B      (unsigned multiply-accumulate per element)
//   mode 1   : C = A + B      (element-wise)
//   mode 2   : C = A^T        (transpose; B is not read)
// Results wider than DATA_W are clamped (SAT=1) or truncated (SAT=0), and
// either case raises the sticky overflow flag for that operation.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset; clears banks, FSM, outputs
//   start       begin an operation (sampled only while idle)
//   mode        operation select, latched with start
//   host_we     host write enable (banks A/B only, ignored while busy)
//   host_sel    bank select: 0 = A, 1 = B, 2 = C, 3 = none (reads 0)
//   host_row    host row index
//   host_col    host column index
//   host_wdata  host write data
//   host_rdata  registered read of the selected element (1-cycle latency)
//   busy        high while an operation is in progress
//   done        one-cycle pulse in the final cycle of an operation
//   overflow    sticky: a result was clamped/truncated in the last operation
module matrix_engine #(
  parameter int DIM    = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2 * DATA_W + 4,
  parameter bit SAT    = 1'b1,
  parameter int IDX_W  = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              host_we,
  input  logic [1:0]        host_sel,
  input  logic [IDX_W-1:0]  host_row,
  input  logic [IDX_W-1:0]  host_col,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int AW = $clog2(DIM * DIM);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);
  localparam logic [IDX_W-1:0]  ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_D   = {DATA_W{1'b0}};
  localparam logic [ACC_W-1:0]  ZERO_ACC = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0]  MAX_ACC  = {{(ACC_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Row-major flat address of element (r, c).
  function automatic logic [AW-1:0] elem_addr(input logic [IDX_W-1:0] r,
                                              input logic [IDX_W-1:0] c);
    elem_addr = AW'(r) * AW'(DIM) + AW'(c);
  endfunction

  // Element-wise operations skip the accumulate phase.
  function automatic logic mode_is_elem(input logic [1:0] m);
    mode_is_elem = (m == 2'd1) || (m == 2'd2);
  endfunction

  // Fit a wide result into DATA_W bits according to SAT.
  function automatic logic [DATA_W-1:0] fit_result(input logic [ACC_W-1:0] v);
    if (v > MAX_ACC) begin
      fit_result = SAT ? {DATA_W{1'b1}} : v[DATA_W-1:0];
    end else begin
      fit_result = v[DATA_W-1:0];
    end
  endfunction

  state_t              state_r, state_next_s;
  logic [1:0]          mode_r;
  logic [IDX_W-1:0]    i_r, j_r, k_r;
  logic [ACC_W-1:0]    acc_r;
  logic [DATA_W-1:0]   a_r [DIM*DIM];
  logic [DATA_W-1:0]   b_r [DIM*DIM];
  logic [DATA_W-1:0]   c_r [DIM*DIM];
  logic [DATA_W-1:0]   host_rdata_r;
  logic                busy_r, done_r, overflow_r;

  logic                accept_s, clr_s, mac_s, wr_s;
  logic                last_elem_s;
  logic [DATA_W-1:0]   mac_a_s, mac_b_s, add_a_s, add_b_s, tr_s;
  logic [ACC_W-1:0]    prod_s;
  logic [DATA_W:0]     add_sum_s;
  logic [ACC_W-1:0]    res_wide_s;
  logic                res_ovf_s;
  logic [DATA_W-1:0]   res_fit_s;
  logic [AW-1:0]       host_addr_s;
  logic                host_in_range_s;
  logic                host_wr_ok_s;
  logic [DATA_W-1:0]   rd_val_s;

  assign last_elem_s = (i_r == LAST_IDX) && (j_r == LAST_IDX);

  // Operand fetch for the three operations.
  assign mac_a_s   = a_r[elem_addr(i_r, k_r)];
  assign mac_b_s   = b_r[elem_addr(k_r, j_r)];
  assign add_a_s   = a_r[elem_addr(i_r, j_r)];
  assign add_b_s   = b_r[elem_addr(i_r, j_r)];
  assign tr_s      = a_r[elem_addr(j_r, i_r)];
  assign prod_s    = ACC_W'(mac_a_s) * ACC_W'(mac_b_s);
  assign add_sum_s = {1'b0, add_a_s} + {1'b0, add_b_s};

  // Host index check; IDX_W may cover more than DIM rows when DIM is not a power of two.
  assign host_in_range_s = ({1'b0, host_row} < (IDX_W + 1)'(DIM)) &&
                           ({1'b0, host_col} < (IDX_W + 1)'(DIM));
  assign host_addr_s  = elem_addr(host_row, host_col);
  assign host_wr_ok_s = host_we && (state_r == ST_IDLE) && host_in_range_s;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. The accepting IDLE cycle already clears the
  // accumulator, so the first element goes straight to MAC/WRITE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = mode_is_elem(mode) ? ST_WRITE : ST_MAC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (mode_is_elem(mode_r)) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_MAC;
        end
      end
      ST_MAC: begin
        if (k_r == LAST_IDX) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_MAC;
        end
      end
      ST_WRITE: begin
        if (last_elem_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_CLEAR;
        end
      end
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    accept_s = 1'b0;
    clr_s    = 1'b0;
    mac_s    = 1'b0;
    wr_s     = 1'b0;
    case (state_r)
      ST_IDLE:  accept_s = start;
      ST_CLEAR: clr_s    = 1'b1;
      ST_MAC:   mac_s    = 1'b1;
      ST_WRITE: wr_s     = 1'b1;
      ST_DONE:  accept_s = 1'b0;
      default:  accept_s = 1'b0;
    endcase
  end

  // Result selection for the element being written.
  always_comb begin
    res_wide_s = acc_r;
    case (mode_r)
      2'd1:    res_wide_s = ACC_W'(add_sum_s);
      2'd2:    res_wide_s = ACC_W'(tr_s);
      default: res_wide_s = acc_r;
    endcase
  end

  assign res_ovf_s = (res_wide_s > MAX_ACC);
  assign res_fit_s = fit_result(res_wide_s);

  // Mode latch, element indices and accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r <= 2'd0;
      i_r    <= ZERO_IDX;
      j_r    <= ZERO_IDX;
      k_r    <= ZERO_IDX;
      acc_r  <= ZERO_ACC;
    end else if (accept_s) begin
      mode_r <= mode;
      i_r    <= ZERO_IDX;
      j_r    <= ZERO_IDX;
      k_r    <= ZERO_IDX;
      acc_r  <= ZERO_ACC;
    end else if (clr_s) begin
      acc_r <= ZERO_ACC;
      k_r   <= ZERO_IDX;
    end else if (mac_s) begin
      acc_r <= acc_r + prod_s;
      k_r   <= (k_r == LAST_IDX) ? ZERO_IDX : (k_r + ONE_IDX);
    end else if (wr_s) begin
      // Row-major walk: j fastest, wrapping into i.
      if (j_r == LAST_IDX) begin
        j_r <= ZERO_IDX;
        i_r <= (i_r == LAST_IDX) ? ZERO_IDX : (i_r + ONE_IDX);
      end else begin
        j_r <= j_r + ONE_IDX;
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  // Operand banks A and B: host writes only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < DIM * DIM; n++) begin
        a_r[n] <= ZERO_D;
        b_r[n] <= ZERO_D;
      end
    end else if (host_wr_ok_s) begin
      if (host_sel == 2'd0) begin
        a_r[host_addr_s] <= host_wdata;
      end else if (host_sel == 2'd1) begin
        b_r[host_addr_s] <= host_wdata;
      end
    end
  end

  // Result bank C: written only by the engine, one element per WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < DIM * DIM; n++) begin
        c_r[n] <= ZERO_D;
      end
    end else if (wr_s) begin
      c_r[elem_addr(i_r, j_r)] <= res_fit_s;
    end
  end

  // Host read mux; the registered copy gives read-before-write on collisions.
  always_comb begin
    rd_val_s = ZERO_D;
    if (!host_in_range_s) begin
      rd_val_s = ZERO_D;
    end else begin
      case (host_sel)
        2'd0:    rd_val_s = a_r[host_addr_s];
        2'd1:    rd_val_s = b_r[host_addr_s];
        2'd2:    rd_val_s = c_r[host_addr_s];
        default: rd_val_s = ZERO_D;
      endcase
    end
  end

  // Registered status and read-data outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rdata_r <= ZERO_D;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      host_rdata_r <= rd_val_s;
      busy_r       <= (state_next_s != ST_IDLE);
      done_r       <= (state_next_s == ST_DONE);
      if (accept_s) begin
        overflow_r <= 1'b0;
      end else if (wr_s && res_ovf_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign host_rdata = host_rdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_matrix_engine.sv
module tb_matrix_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic       host_we;
  logic [1:0] host_sel;
  logic [1:0] host_row;
  logic [1:0] host_col;
  logic [7:0] host_wdata;

  logic [7:0] rdata_sat, rdata_wrap, rdata_d2;
  logic       busy_sat, busy_wrap, busy_d2;
  logic       done_sat, done_wrap, done_d2;
  logic       ovf_sat, ovf_wrap, ovf_d2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  matrix_engine #(.DIM(4), .DATA_W(8), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .host_we(host_we), .host_sel(host_sel), .host_row(host_row), .host_col(host_col),
    .host_wdata(host_wdata), .host_rdata(rdata_sat),
    .busy(busy_sat), .done(done_sat), .overflow(ovf_sat));

  matrix_engine #(.DIM(4), .DATA_W(8), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .host_we(host_we), .host_sel(host_sel), .host_row(host_row), .host_col(host_col),
    .host_wdata(host_wdata), .host_rdata(rdata_wrap),
    .busy(busy_wrap), .done(done_wrap), .overflow(ovf_wrap));

  matrix_engine #(.DIM(2), .DATA_W(8), .SAT(1'b1)) u_d2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .host_we(host_we), .host_sel(host_sel), .host_row(host_row[0]), .host_col(host_col[0]),
    .host_wdata(host_wdata), .host_rdata(rdata_d2),
    .busy(busy_d2), .done(done_d2), .overflow(ovf_d2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input int r, input int c, input int d);
    host_we    = 1'b1;
    host_sel   = sel;
    host_row   = 2'(r);
    host_col   = 2'(c);
    host_wdata = 8'(d);
    tick;
    host_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, input int r, input int c);
    host_we  = 1'b0;
    host_sel = sel;
    host_row = 2'(r);
    host_col = 2'(c);
    tick;
  endtask

  function automatic logic busy_of(input int w);
    case (w)
      0:       return busy_sat;
      1:       return busy_wrap;
      default: return busy_d2;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      0:       return done_sat;
      1:       return done_wrap;
      default: return done_d2;
    endcase
  endfunction

  // Start an operation and count busy cycles/done pulses on instance w.
  // At busy cycle disturb_at (0 = never) pulse start and try to write A[0][0]=9.
  task automatic run_op(input int w, input logic [1:0] md, input int disturb_at,
                        output int cycles, output int dones);
    mode  = md;
    start = 1'b1;
    tick;
    start  = 1'b0;
    cycles = 0;
    dones  = 0;
    while (busy_of(w) && cycles < 500) begin
      cycles++;
      if (done_of(w)) dones++;
      if (cycles == disturb_at) begin
        start = 1'b1; host_we = 1'b1; host_sel = 2'd0;
        host_row = 2'd0; host_col = 2'd0; host_wdata = 8'd9;
      end else begin
        start = 1'b0; host_we = 1'b0;
      end
      tick;
    end
    start   = 1'b0;
    host_we = 1'b0;
  endtask

  initial begin
    int cyc, dn;
    int ma [4][4];
    int mb [4][4];
    int exps [4][4];
    int expw [4][4];
    int sum;
    bit eov;
    bit seen_done;

    reset = 1'b0; start = 1'b0; mode = 2'd0; host_we = 1'b0;
    host_sel = 2'd0; host_row = 2'd0; host_col = 2'd0; host_wdata = 8'd0;
    tick; tick;
    check("rst_busy", busy_sat, 1'b0);
    check("rst_done", done_sat, 1'b0);
    check("rst_ovf", ovf_sat, 1'b0);
    check("rst_rdata", rdata_sat, 8'd0);
    reset = 1'b1;
    tick;

    // Multiply: identity * B = B
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(2'd0, r, c, (r == c) ? 1 : 0);
        wr(2'd1, r, c, 4 * r + c);
      end
    run_op(0, 2'd0, 0, cyc, dn);
    check("mul_cycles", cyc, 96);
    check("mul_dones", dn, 1);
    check("mul_done_after", done_sat, 1'b0);
    check("mul_ovf", ovf_sat, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rd(2'd2, r, c);
        check($sformatf("mul_c[%0d][%0d]", r, c), rdata_sat, 4 * r + c);
      end

    // Element-wise add: 200 + 100 saturates to 255 or wraps to 44
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(2'd0, r, c, 200);
        wr(2'd1, r, c, 100);
      end
    run_op(0, 2'd1, 0, cyc, dn);
    check("add_cycles", cyc, 32);
    check("add_dones", dn, 1);
    check("add_ovf_sat", ovf_sat, 1'b1);
    check("add_ovf_wrap", ovf_wrap, 1'b1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rd(2'd2, r, c);
        check($sformatf("add_sat[%0d][%0d]", r, c), rdata_sat, 255);
        check($sformatf("add_wrap[%0d][%0d]", r, c), rdata_wrap, 44);
      end

    // Transpose
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = 16 * r + c;
        wr(2'd0, r, c, ma[r][c]);
      end
    run_op(0, 2'd2, 0, cyc, dn);
    check("tr_cycles", cyc, 32);
    check("tr_dones", dn, 1);
    check("tr_ovf_cleared", ovf_sat, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rd(2'd2, r, c);
        check($sformatf("tr_c[%0d][%0d]", r, c), rdata_sat, 16 * c + r);
      end
    rd(2'd1, 2, 1);
    check("tr_b_untouched", rdata_sat, 100);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mb[r][c] = r + c + 1;
        wr(2'd1, r, c, mb[r][c]);
      end
    rd(2'd1, 3, 2);
    check("b_loaded", rdata_sat, 6);
    wr(2'd2, 0, 1, 77);
    rd(2'd2, 0, 1);
    check("c_host_write_ignored", rdata_sat, 16);
    wr(2'd3, 0, 1, 77);
    check("sel3_reads_zero", rdata_sat, 0);
    wr(2'd0, 0, 0, 5);
    check("collision_old_value", rdata_sat, 0);
    rd(2'd0, 0, 0);
    check("collision_new_value", rdata_sat, 5);
    wr(2'd0, 0, 0, 0);

    // Busy protection on a multiply, checked against a reference product
    eov = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        sum = 0;
        for (int k = 0; k < 4; k++) sum += ma[r][k] * mb[k][c];
        exps[r][c] = (sum > 255) ? 255 : sum;
        expw[r][c] = sum % 256;
        if (sum > 255) eov = 1'b1;
      end
    run_op(0, 2'd0, 10, cyc, dn);
    check("prot_cycles", cyc, 96);
    check("prot_dones", dn, 1);
    check("prot_ovf_sat", ovf_sat, eov);
    check("prot_ovf_wrap", ovf_wrap, eov);
    rd(2'd0, 0, 0);
    check("prot_a00_kept", rdata_sat, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rd(2'd2, r, c);
        check($sformatf("prod_sat[%0d][%0d]", r, c), rdata_sat, exps[r][c]);
        check($sformatf("prod_wrap[%0d][%0d]", r, c), rdata_wrap, expw[r][c]);
      end

    // Reserved mode executes as a multiply
    wr(2'd0, 0, 0, 1);
    run_op(0, 2'd3, 0, cyc, dn);
    check("m3_cycles", cyc, 96);
    rd(2'd2, 0, 0);
    check("m3_c00", rdata_sat, exps[0][0] + 1);
    rd(2'd2, 3, 0);
    check("m3_c30", rdata_sat, exps[3][0]);

    // Reset at busy cycle 40 of a multiply
    mode  = 2'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (39) tick;
    check("pre_reset_busy", busy_sat, 1'b1);
    reset = 1'b0;
    #1;
    check("reset_busy_now", busy_sat, 1'b0);
    check("reset_done_now", done_sat, 1'b0);
    seen_done = 1'b0;
    repeat (3) begin
      tick;
      if (done_sat) seen_done = 1'b1;
    end
    reset = 1'b1;
    repeat (4) begin
      tick;
      if (done_sat) seen_done = 1'b1;
    end
    check("reset_no_done", seen_done, 1'b0);
    rd(2'd0, 2, 3);
    check("reset_a23", rdata_sat, 0);
    rd(2'd1, 3, 3);
    check("reset_b33", rdata_sat, 0);
    rd(2'd2, 3, 3);
    check("reset_c33", rdata_sat, 0);

    // DIM=2 multiply: [[1,2],[3,4]] * [[5,6],[7,8]] = [[19,22],[43,50]]
    wr(2'd0, 0, 0, 1); wr(2'd0, 0, 1, 2); wr(2'd0, 1, 0, 3); wr(2'd0, 1, 1, 4);
    wr(2'd1, 0, 0, 5); wr(2'd1, 0, 1, 6); wr(2'd1, 1, 0, 7); wr(2'd1, 1, 1, 8);
    run_op(2, 2'd0, 0, cyc, dn);
    check("d2_cycles", cyc, 16);
    check("d2_dones", dn, 1);
    check("d2_ovf", ovf_d2, 1'b0);
    rd(2'd2, 0, 0); check("d2_c00", rdata_d2, 19);
    rd(2'd2, 0, 1); check("d2_c01", rdata_d2, 22);
    rd(2'd2, 1, 0); check("d2_c10", rdata_d2, 43);
    rd(2'd2, 1, 1); check("d2_c11", rdata_d2, 50);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
